// File: rtl/reflet_int_ctrl_pkg.sv
// Shared constants and helpers for the reflet interrupt controller.
// The register offsets match the values in reflet_int_ctrl.vh.
package reflet_int_ctrl_pkg;

    localparam int NB_INT  = 4;
    localparam int NB_REGS = 6;

    localparam logic [2:0] INT_PENDING = 3'd0;
    localparam logic [2:0] INT_MASK    = 3'd1;
    localparam logic [2:0] INT_MODE    = 3'd2;
    localparam logic [2:0] INT_SET     = 3'd3;
    localparam logic [2:0] INT_TRELOAD = 3'd4;
    localparam logic [2:0] INT_TCTRL   = 3'd5;

    // A set and a clear of the same bit in one cycle leaves the bit set.
    function automatic logic [NB_INT-1:0] pending_update(
        input logic [NB_INT-1:0] pending,
        input logic [NB_INT-1:0] set_mask,
        input logic [NB_INT-1:0] clr_mask
    );
        return (pending & ~clr_mask) | set_mask;
    endfunction

endpackage

// File: rtl/reflet_int_ctrl.vh
// Register offsets and source count for the reflet interrupt controller, for firmware-test benches.
// The RTL takes the same constants from reflet_int_ctrl_pkg.
`ifndef REFLET_INT_CTRL_VH
`define REFLET_INT_CTRL_VH
`define INT_PENDING 0
`define INT_MASK    1
`define INT_MODE    2
`define INT_SET     3
`define INT_TRELOAD 4
`define INT_TCTRL   5
`define NB_INT      4
`endif

// File: rtl/reflet_int_sync_edge.sv
// One interrupt source: 2-flop synchroniser followed by rising-edge or level selection.
// The synchroniser and edge history run even while disabled so that resuming never fakes an edge.
module reflet_int_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic src,
    input  logic level_mode,
    output logic evt
);

    logic [1:0] sync_reg;
    logic       prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], src};
            prev_reg <= sync_reg[1];
        end
    end

    assign evt = enable & (level_mode ? sync_reg[1] : (sync_reg[1] & ~prev_reg));

endmodule

// File: rtl/reflet_int_ctrl.sv
// Memory-mapped interrupt controller driving reflet_cpu ext_int[3:0].
// Define REFLET_INT_CTRL_TIMER_EN to add the down-counter timer that feeds source 3.
module reflet_int_ctrl
    import reflet_int_ctrl_pkg::*;
#(
    parameter int wordsize  = 16,
    parameter int base_addr = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    input  logic [NB_INT-1:0]   src,
    output logic [NB_INT-1:0]   ext_int
);

    logic [wordsize-1:0] offset;
    logic                hit;
    logic [2:0]          reg_sel;
    logic                bus_wr;
    logic                wr_pending, wr_mask, wr_mode, wr_set;

    logic [NB_INT-1:0]   pending_reg, pending_next;
    logic [NB_INT-1:0]   mask_reg, mask_next;
    logic [NB_INT-1:0]   mode_reg, mode_next;
    logic [NB_INT-1:0]   ext_int_reg;
    logic [wordsize-1:0] data_out_reg, rd_next;
    logic [NB_INT-1:0]   src_evt, set_vec, clr_vec;
    logic                timer_evt;

    // Wrapping subtraction: addresses below base_addr land far above NB_REGS.
    assign offset  = addr - wordsize'(base_addr);
    assign hit     = offset < wordsize'(NB_REGS);
    assign reg_sel = offset[2:0];
    assign bus_wr  = write_en & hit;

    assign wr_pending = bus_wr && (reg_sel == INT_PENDING);
    assign wr_mask    = bus_wr && (reg_sel == INT_MASK);
    assign wr_mode    = bus_wr && (reg_sel == INT_MODE);
    assign wr_set     = bus_wr && (reg_sel == INT_SET);

    genvar gi;
    generate
        for (gi = 0; gi < NB_INT; gi++) begin : g_src
            reflet_int_sync_edge u_sync (
                .clk        (clk),
                .reset      (reset),
                .enable     (enable),
                .src        (src[gi]),
                .level_mode (mode_reg[gi]),
                .evt        (src_evt[gi])
            );
        end
    endgenerate

`ifdef REFLET_INT_CTRL_TIMER_EN
    logic                wr_treload, wr_tctrl;
    logic [wordsize-1:0] treload_reg, treload_next;
    logic [wordsize-1:0] cnt_reg, cnt_next;
    logic [1:0]          tctrl_reg, tctrl_next;
    logic                tevt_reg, tevt_next;

    assign wr_treload = bus_wr && (reg_sel == INT_TRELOAD);
    assign wr_tctrl   = bus_wr && (reg_sel == INT_TCTRL);

    // tctrl bit0 = run, bit1 = auto-reload. The event fires on the 1->0 step;
    // the following cycle either reloads or drops run.
    always_comb begin
        treload_next = wr_treload ? data_in : treload_reg;
        tctrl_next   = tctrl_reg;
        cnt_next     = cnt_reg;
        tevt_next    = 1'b0;
        if (wr_tctrl) begin
            tctrl_next = data_in[1:0];
            if (data_in[0])
                cnt_next = treload_reg;
        end else if (tctrl_reg[0]) begin
            if (cnt_reg == wordsize'(1)) begin
                cnt_next  = '0;
                tevt_next = 1'b1;
            end else if (cnt_reg == '0) begin
                if (tctrl_reg[1] && (treload_reg != '0))
                    cnt_next = treload_reg;
                else
                    tctrl_next[0] = 1'b0;
            end else begin
                cnt_next = cnt_reg - wordsize'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            treload_reg <= '0;
            tctrl_reg   <= '0;
            cnt_reg     <= '0;
            tevt_reg    <= 1'b0;
        end else if (enable) begin
            treload_reg <= treload_next;
            tctrl_reg   <= tctrl_next;
            cnt_reg     <= cnt_next;
            tevt_reg    <= tevt_next;
        end
    end

    assign timer_evt = tevt_reg;
`else
    logic unused_data;
    assign unused_data = ^data_in[wordsize-1:NB_INT];
    assign timer_evt   = 1'b0;
`endif

    always_comb begin
        rd_next = '0;
        if (hit) begin
            case (reg_sel)
                INT_PENDING: rd_next[NB_INT-1:0] = pending_reg;
                INT_MASK:    rd_next[NB_INT-1:0] = mask_reg;
                INT_MODE:    rd_next[NB_INT-1:0] = mode_reg;
                INT_SET:     rd_next = '0;
`ifdef REFLET_INT_CTRL_TIMER_EN
                INT_TRELOAD: rd_next = treload_reg;
                INT_TCTRL:   rd_next[1:0] = tctrl_reg;
`else
                INT_TRELOAD, INT_TCTRL: rd_next = '0;
`endif
                default:     rd_next = '0;
            endcase
        end
    end

    always_comb begin
        set_vec      = src_evt | {timer_evt, {(NB_INT-1){1'b0}}}
                     | (wr_set ? data_in[NB_INT-1:0] : '0);
        clr_vec      = wr_pending ? data_in[NB_INT-1:0] : '0;
        pending_next = pending_update(pending_reg, set_vec, clr_vec);
        mask_next    = wr_mask ? data_in[NB_INT-1:0] : mask_reg;
        mode_next    = wr_mode ? data_in[NB_INT-1:0] : mode_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg  <= '0;
            mask_reg     <= '0;
            mode_reg     <= '0;
            ext_int_reg  <= '0;
            data_out_reg <= '0;
        end else if (enable) begin
            pending_reg  <= pending_next;
            mask_reg     <= mask_next;
            mode_reg     <= mode_next;
            ext_int_reg  <= pending_reg & mask_reg;
            data_out_reg <= rd_next;
        end
    end

    assign ext_int  = ext_int_reg;
    assign data_out = data_out_reg;

endmodule

// File: tb/tb_reflet_int_ctrl.sv
// Self-checking bench for reflet_int_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a history-based reference model.
module tb_reflet_int_ctrl;

    localparam int BASE = 'h40;

    logic        clk = 1'b0;
    logic        reset, enable, write_en;
    logic [15:0] addr, data_in;
    logic [3:0]  src;
    wire  [15:0] data_out;
    wire  [3:0]  ext_int;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    reflet_int_ctrl #(.wordsize(16), .base_addr(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .addr     (addr),
        .data_in  (data_in),
        .write_en (write_en),
        .data_out (data_out),
        .src      (src),
        .ext_int  (ext_int)
    );

    always #5 clk = ~clk;

    // Reference model state. h0/h1/h2 = src as sampled 1/2/3 edges ago.
    logic [3:0]  m_pend = '0, m_mask = '0, m_mode = '0, m_ext = '0;
    logic [3:0]  h0 = '0, h1 = '0, h2 = '0;
    logic [15:0] m_dout = '0, m_trel = '0;
    logic        m_run = 1'b0, m_auto = 1'b0, m_tev = 1'b0;
    int          m_age = 0, m_per = 0;

    function automatic logic [15:0] model_read(input int off);
        case (off)
            0: return {12'h0, m_pend};
            1: return {12'h0, m_mask};
            2: return {12'h0, m_mode};
`ifdef REFLET_INT_CTRL_TIMER_EN
            4: return m_trel;
            5: return {14'h0, m_auto, m_run};
`endif
            default: return 16'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int          off, age;
        bit          hit, wr;
        logic [3:0]  ev, setv, clrv;
        logic        fire;
        cyc <= cyc + 1;
        if (reset) begin
            m_pend <= '0; m_mask <= '0; m_mode <= '0; m_ext <= '0; m_dout <= '0;
            h0 <= '0; h1 <= '0; h2 <= '0;
            m_trel <= '0; m_run <= 1'b0; m_auto <= 1'b0; m_tev <= 1'b0; m_age <= 0; m_per <= 0;
        end else begin
            h0 <= src; h1 <= h0; h2 <= h1;
            if (enable) begin
                off = int'(addr) - BASE;
                hit = (off >= 0) && (off < 6);
                wr  = write_en && hit;
                m_dout <= hit ? model_read(off) : 16'h0;
                m_ext  <= m_pend & m_mask;
                for (int i = 0; i < 4; i++)
                    ev[i] = m_mode[i] ? h1[i] : (h1[i] & ~h2[i]);
                setv = (wr && off == 3) ? data_in[3:0] : 4'h0;
                clrv = (wr && off == 0) ? data_in[3:0] : 4'h0;
                fire = 1'b0;
`ifdef REFLET_INT_CTRL_TIMER_EN
                setv[3] = setv[3] | m_tev;
                if (wr && off == 5) begin
                    m_run <= data_in[0]; m_auto <= data_in[1]; m_age <= 0; m_per <= int'(m_trel);
                end else if (m_run) begin
                    age = m_age + 1;
                    if (m_per != 0 && age == m_per) fire = 1'b1;
                    if (age == m_per + 1) begin
                        if (m_auto && m_trel != 0) begin m_age <= 0; m_per <= int'(m_trel); end
                        else m_run <= 1'b0;
                    end else m_age <= age;
                end
                if (wr && off == 4) m_trel <= data_in;
`endif
                m_tev  <= fire;
                m_pend <= (m_pend & ~clrv) | ev | setv;
                if (wr && off == 1) m_mask <= data_in[3:0];
                if (wr && off == 2) m_mode <= data_in[3:0];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_checks++;
            if (data_out !== m_dout) begin
                n_err++;
                $display("FAIL cyc_data_out @%0d: got %h expected %h", cyc, data_out, m_dout);
            end
            n_checks++;
            if (ext_int !== m_ext) begin
                n_err++;
                $display("FAIL cyc_ext_int @%0d: got %h expected %h", cyc, ext_int, m_ext);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("check %s: %h", name, act);
        end
    endtask

    task automatic wr(input int off, input logic [15:0] d);
        addr = 16'(BASE + off); data_in = d; write_en = 1'b1;
        tick();
        write_en = 1'b0; addr = 16'(BASE);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; write_en = 1'b0; addr = 16'(BASE); data_in = '0; src = '0;
        tick(); tick();
        chk_on = 1'b1;
        reset = 1'b0;
        check("reset_ext", {12'h0, ext_int}, 16'h0);
        check("reset_dout", data_out, 16'h0);

        // 1) edge source 0: pending after 3 edges, ext_int after 4, clear drops ext_int.
        wr(1, 16'h1);
        src[0] = 1'b1;
        tick(); tick(); tick();
        check("t1_ext_at3", {12'h0, ext_int}, 16'h0);
        check("t1_rd_lat", data_out, 16'h0);
        tick();
        check("t1_ext_at4", {12'h0, ext_int}, 16'h1);
        check("t1_rd_pend", data_out, 16'h1);
        tick(); src[0] = 1'b0;
        repeat (3) tick();
        wr(0, 16'h1);
        check("t1_ext_hold", {12'h0, ext_int}, 16'h1);
        tick();
        check("t1_ext_clr", {12'h0, ext_int}, 16'h0);

        // 2) level source 1 survives a clear while high.
        wr(2, 16'h2); wr(1, 16'h2);
        src[1] = 1'b1;
        repeat (4) tick();
        wr(0, 16'h2);
        tick();
        check("t2_level_stays", data_out, 16'h2);
        src[1] = 1'b0;
        repeat (3) tick();
        wr(0, 16'h2);
        tick(); tick();
        check("t2_ext_clr", {12'h0, ext_int}, 16'h0);

        // 3) masked source latches; unmasking raises ext_int next cycle.
        wr(1, 16'h0); wr(2, 16'h0);
        src[2] = 1'b1; tick(); tick(); src[2] = 1'b0;
        repeat (4) tick();
        check("t3_masked_ext", {12'h0, ext_int}, 16'h0);
        check("t3_rd_pend", data_out, 16'h4);
        wr(1, 16'h4);
        check("t3_ext_before", {12'h0, ext_int}, 16'h0);
        tick();
        check("t3_ext_unmask", {12'h0, ext_int}, 16'h4);

        // 4) set beats a same-cycle clear; software SET raises ext_int[3].
        wr(0, 16'hF); wr(1, 16'h0);
        src[0] = 1'b1; tick(); tick();
        wr(0, 16'h1);
        tick();
        check("t4_set_wins", data_out, 16'h1);
        src[0] = 1'b0;
        wr(1, 16'h8); wr(3, 16'h8);
        tick();
        check("t4_sw_set", {12'h0, ext_int}, 16'h8);
        addr = 16'(BASE + 3); tick();
        check("t4_set_reads0", data_out, 16'h0);
        addr = 16'(BASE + 6); tick();
        check("t4_undecoded", data_out, 16'h0);
        addr = 16'(BASE);

        // 5) events during enable=0 are dropped; reset clears pending=0xF.
        wr(0, 16'hF); wr(1, 16'h1);
        enable = 1'b0; src[0] = 1'b1;
        repeat (3) tick();
        src[0] = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (4) tick();
        check("t5_no_ext", {12'h0, ext_int}, 16'h0);
        check("t5_no_pend", data_out, 16'h0);
        wr(1, 16'hF); wr(3, 16'hF);
        tick(); tick();
        check("t5_all_ext", {12'h0, ext_int}, 16'hF);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t5_rst_ext", {12'h0, ext_int}, 16'h0);
        check("t5_rst_dout", data_out, 16'h0);

`ifdef REFLET_INT_CTRL_TIMER_EN
        // 6) auto-reload period of TRELOAD+1, then a single one-shot event.
        begin
            int  rises[$];
            bit  prev;
            wr(1, 16'h8); wr(4, 16'h5); wr(5, 16'h3);
            prev = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (ext_int[3] && !prev) rises.push_back(cyc);
                prev = ext_int[3];
                if (ext_int[3]) wr(0, 16'h8); else tick();
            end
            check("t6_rise_count_ok", 16'(rises.size() >= 3), 16'h1);
            for (int k = 1; k < rises.size(); k++)
                check("t6_period", 16'(rises[k] - rises[k-1]), 16'd6);
            wr(5, 16'h0);
            repeat (10) tick();
            wr(0, 16'hF); tick(); tick();
            wr(5, 16'h1);
            rises.delete();
            prev = 1'b0;
            for (int c = 0; c < 30; c++) begin
                if (ext_int[3] && !prev) rises.push_back(cyc);
                prev = ext_int[3];
                if (ext_int[3]) wr(0, 16'h8); else tick();
            end
            check("t6_oneshot", 16'(rises.size()), 16'd1);
            addr = 16'(BASE + 5); tick();
            check("t6_tctrl_rd", data_out, 16'h0);
            addr = 16'(BASE);
        end
`endif

        // Randomized traffic, compared every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            int off;
            if ($urandom_range(0, 3) == 0) src = src ^ 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 15) != 0);
            reset  = ($urandom_range(0, 299) == 0);
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) begin
                write_en = 1'b1;
                addr     = 16'(BASE + off);
                data_in  = (off == 4) ? 16'($urandom_range(0, 8)) : 16'($urandom);
            end else begin
                write_en = 1'b0;
                addr     = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(BASE + off);
                data_in  = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) addr = 16'(BASE - 1);
            tick();
        end
        reset = 1'b0; enable = 1'b1; write_en = 1'b0;
        tick();
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
